// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default bit period.
`timescale 1ns/1ps
package uart_rx_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; free-running, resets to RESET_VAL.
`timescale 1ns/1ps
module sync_2ff #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // metastability chain, deliberately not gated by any enable
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation at half period, mid-bit sampling, registered strobes.
`timescale 1ns/1ps
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       rx,
  output logic       byte_dv,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);

  logic       rx_s;
  rx_state_e  state_r;
  rx_state_e  state_nxt_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic [2:0] idx_r;
  logic [2:0] idx_nxt_s;
  logic [7:0] shift_r;
  logic [7:0] byte_r;
  logic       byte_dv_r;
  logic       frame_err_r;
  logic       sample_s;
  logic       dv_set_s;
  logic       err_set_s;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next state, bit counter and data index; everything holds while ce is low
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    if (ce) begin
      case (state_r)
        IDLE: begin
          cnt_nxt_s = 16'd0;
          if (!rx_s) begin
            state_nxt_s = START;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        START: begin
          if (cnt_r == HALF_CNT) begin
            cnt_nxt_s   = 16'd0;
            idx_nxt_s   = 3'd0;
            // a start bit that is high again at mid-bit was only a glitch
            state_nxt_s = rx_s ? IDLE : DATA;
          end else begin
            cnt_nxt_s = cnt_r + 16'd1;
          end
        end
        DATA: begin
          if (cnt_r == LAST_CNT) begin
            cnt_nxt_s = 16'd0;
            if (idx_r == 3'd7) begin
              state_nxt_s = STOP;
            end else begin
              idx_nxt_s = idx_r + 3'd1;
            end
          end else begin
            cnt_nxt_s = cnt_r + 16'd1;
          end
        end
        STOP: begin
          if (cnt_r == LAST_CNT) begin
            cnt_nxt_s   = 16'd0;
            state_nxt_s = IDLE;
          end else begin
            cnt_nxt_s = cnt_r + 16'd1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 16'd0;
          idx_nxt_s   = 3'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // sample and strobe decode; ce is folded in so a held enable kills the strobes
  always_comb begin
    sample_s  = 1'b0;
    dv_set_s  = 1'b0;
    err_set_s = 1'b0;
    if (ce && (cnt_r == LAST_CNT)) begin
      case (state_r)
        DATA:    sample_s  = 1'b1;
        STOP: begin
          dv_set_s  = rx_s;
          err_set_s = ~rx_s;
        end
        default: sample_s = 1'b0;
      endcase
    end else begin
      sample_s = 1'b0;
    end
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= 16'd0;
      idx_r       <= 3'd0;
      shift_r     <= 8'h00;
      byte_r      <= 8'h00;
      byte_dv_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      idx_r       <= idx_nxt_s;
      byte_dv_r   <= dv_set_s;
      frame_err_r <= err_set_s;
      if (sample_s) begin
        shift_r[idx_r] <= rx_s;
      end
      if (dv_set_s) begin
        byte_r <= shift_r;
      end
    end
  end

  assign byte_dv   = byte_dv_r;
  assign frame_err = frame_err_r;
  assign rx_byte   = byte_r;

endmodule
